// File: rtl/mu0_mem_resp_if.sv
// MU0 memory bus: requester drives address, strobes and write data; responder returns data and status.
interface mu0_mem_resp_if;
  logic [11:0] Addr;
  logic        Rd;
  logic        Wr;
  logic [15:0] Din;
  logic [15:0] Dout;
  logic        Ready;
  logic        Err;
  logic        Busy;

  modport master (output Addr, Rd, Wr, Din, input Dout, Ready, Err, Busy);
  modport slave  (input Addr, Rd, Wr, Din, output Dout, Ready, Err, Busy);
endinterface

// File: rtl/mu0_mem_resp.sv
// MU0 memory responder: 2^DEPTH_LOG2 x 16 RAM answering Rd/Wr strobes with a registered Ready/Err pulse.
// Define MU0_MEM_WAIT_EN to insert WAIT_CYCLES wait states per access; otherwise latency is fixed at one cycle.
module mu0_mem_resp #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 8
) (
  input logic           Clk,
  input logic           Reset,
  mu0_mem_resp_if.slave bus
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [15:0]           mem [WORDS];
  logic                  start;
  logic                  both;
  logic                  oor;
  logic                  err_q;
  logic                  ready_q;
  logic                  err_out_q;
  logic [15:0]           dout_q;
  logic                  mem_go;
  logic                  op_wr;
  logic [DEPTH_LOG2-1:0] op_addr;
  logic [15:0]           op_din;

  assign start = bus.Rd ^ bus.Wr;
  assign both  = bus.Rd & bus.Wr;
  assign oor   = |(bus.Addr >> DEPTH_LOG2);

`ifdef MU0_MEM_WAIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                state;
  state_t                nxt;
  logic [3:0]            cnt;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  wr_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [15:0]           din_q;

  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (both) begin
          nxt = DONE;
        end else if (start) begin
          nxt      = WAIT;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) nxt = DONE;
        else             cnt_dec = 1'b1;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= 4'd0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= 16'h0000;
    end else begin
      if (cnt_load)     cnt <= WAIT_LOAD;
      else if (cnt_dec) cnt <= cnt - 4'd1;
      if (state == IDLE && start) begin
        wr_q   <= bus.Wr;
        addr_q <= bus.Addr[DEPTH_LOG2-1:0];
        din_q  <= bus.Din;
      end
    end
  end

  // Memory is touched only on the edge leaving WAIT, so a reset mid-wait drops the access.
  assign mem_go  = (state == WAIT) && (cnt == 4'd0) && !err_q && !Reset;
  assign op_wr   = wr_q;
  assign op_addr = addr_q;
  assign op_din  = din_q;
`else
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

  state_t state;
  state_t nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start || both) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Access happens on the same edge the request is accepted, so operands come straight from the bus.
  assign mem_go  = (state == IDLE) && start && !oor && !Reset;
  assign op_wr   = bus.Wr;
  assign op_addr = bus.Addr[DEPTH_LOG2-1:0];
  assign op_din  = bus.Din;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      err_out_q <= 1'b0;
      dout_q    <= 16'h0000;
    end else begin
      if (state == IDLE && (start || both)) err_q <= both || oor;
      ready_q   <= (state == DONE);
      err_out_q <= (state == DONE) && err_q;
      if (mem_go && !op_wr) dout_q <= mem[op_addr];
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_go && op_wr) mem[op_addr] <= op_din;
  end

  assign bus.Dout  = dout_q;
  assign bus.Ready = ready_q;
  assign bus.Err   = err_out_q;
  assign bus.Busy  = (state != IDLE);

endmodule

// File: tb/tb_mu0_mem_resp.sv
// Directed bench for mu0_mem_resp: latency, data, error cases, back-to-back and async reset abort.
module tb_mu0_mem_resp;
  localparam int WAIT_CYCLES = 2;
`ifdef MU0_MEM_WAIT_EN
  localparam int LAT   = WAIT_CYCLES + 1;
  localparam bit WAITS = 1'b1;
`else
  localparam int LAT   = 1;
  localparam bit WAITS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mu0_mem_resp_if bus ();

  mu0_mem_resp #(.WAIT_CYCLES(WAIT_CYCLES), .DEPTH_LOG2(8)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge; Ready counted in negedges after the sampling edge.
  task automatic access(input string tag, input bit rd, input bit wr, input logic [11:0] a,
                        input logic [15:0] d, input logic [15:0] exp_dout, input bit exp_err);
    int n;
    int exp_n;
    n      = 0;
    exp_n  = (rd && wr) ? 2 : LAT + 1;
    bus.Rd = rd;
    bus.Wr = wr;
    bus.Addr = a;
    bus.Din  = d;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.Addr = ~a;
        bus.Din  = ~d;
      end
      if (bus.Ready) break;
      check({tag, "_busy"}, bus.Busy, 1);
      check({tag, "_err_idle"}, bus.Err, 0);
    end
    check({tag, "_lat"}, n, exp_n);
    check({tag, "_ready"}, bus.Ready, 1);
    check({tag, "_err"}, bus.Err, exp_err);
    check({tag, "_dout"}, bus.Dout, exp_dout);
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, {bus.Ready, bus.Err, bus.Busy}, 3'b000);
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.Ready && n < 20);
    check({tag, "_lat"}, n, LAT + 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    bus.Addr = 12'h000;
    bus.Din  = 16'h0000;
    #3;
    check("rst_ready", bus.Ready, 0);
    check("rst_err", bus.Err, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_dout", bus.Dout, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    access("wr010", 1'b0, 1'b1, 12'h010, 16'h1234, 16'h0000, 1'b0);
    access("rd010", 1'b1, 1'b0, 12'h010, 16'h0000, 16'h1234, 1'b0);
    access("wr005", 1'b0, 1'b1, 12'h005, 16'h5555, 16'h1234, 1'b0);
    access("both005", 1'b1, 1'b1, 12'h005, 16'h9999, 16'h1234, 1'b1);
    access("rd005", 1'b1, 1'b0, 12'h005, 16'h0000, 16'h5555, 1'b0);
    access("wr000", 1'b0, 1'b1, 12'h000, 16'h0A0A, 16'h5555, 1'b0);
    access("wr100", 1'b0, 1'b1, 12'h100, 16'hBEEF, 16'h5555, 1'b1);
    access("rd000", 1'b1, 1'b0, 12'h000, 16'h0000, 16'h0A0A, 1'b0);
    access("rd1ff", 1'b1, 1'b0, 12'h1FF, 16'h0000, 16'h0A0A, 1'b1);

    // Back-to-back: strobe stays high across Ready, second address presented in the idle cycle.
    bus.Rd = 1'b1;
    bus.Addr = 12'h005;
    wait_ready("b2b_a", n);
    check("b2b_a_dout", bus.Dout, 16'h5555);
    bus.Addr = 12'h010;
    wait_ready("b2b_b", n);
    check("b2b_b_dout", bus.Dout, 16'h1234);
    check("b2b_b_err", bus.Err, 0);
    bus.Rd = 1'b0;
    @(negedge clk);

    access("wr020", 1'b0, 1'b1, 12'h020, 16'h1111, 16'h1234, 1'b0);

    // Reset between clock edges while the write to 0x020 is in flight.
    bus.Wr = 1'b1;
    bus.Addr = 12'h020;
    bus.Din  = 16'hAAAA;
    @(negedge clk);
    check("mid_busy", bus.Busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_outs", {bus.Ready, bus.Err, bus.Busy}, 3'b000);
    check("mid_rst_dout", bus.Dout, 16'h0000);
    bus.Wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access("rd020", 1'b1, 1'b0, 12'h020, 16'h0000, WAITS ? 16'h1111 : 16'hAAAA, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mu0_mem_resp.md
MU0_MEM_RESP -- requirements
Module: mu0_mem_resp

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, number of wait states inserted per access when wait states are compiled in (legal 1..15).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, log2 of implemented word count (256 words x 16 bits).
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Addr  input  12  word address from MU0 address bus.
REQ-006 SHALL have port Rd  input  1  read request strobe, held by requester until Ready.
REQ-007 SHALL have port Wr  input  1  write request strobe, held by requester until Ready.
REQ-008 SHALL have port Din  input  16  write data from requester.
REQ-009 SHALL have port Dout  output  16  read data, registered.
REQ-010 SHALL have port Ready  output  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port Err  output  1  error flag, valid only while Ready high.
REQ-012 SHALL have port Busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM with states IDLE, WAIT, DONE.
REQ-014 IDLE: on edge with Rd xor Wr high, SHALL latch Addr, Din and operation, then go to WAIT (macro defined) or DONE (macro undefined).
REQ-015 IDLE: on edge with Rd and Wr both high, SHALL latch nothing, go to DONE with error flagged; no memory access.
REQ-016 WAIT: SHALL decrement a 4-bit counter loaded with WAIT_CYCLES-1 on entry; go to DONE on edge where counter is 0.
REQ-017 DONE: SHALL assert Ready for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Write commits to memory on the edge entering DONE; Dout updates with read data on the same edge, so Dout is valid while Ready high.
REQ-019 Dout SHALL hold its last read value through writes, errors and idle cycles.
REQ-020 Address out of range (Addr[11:DEPTH_LOG2] non-zero) SHALL give Err=1 with Ready, no write, Dout unchanged.
REQ-021 Rd/Wr, Addr and Din changes during WAIT or DONE SHALL be ignored; only latched values are used.
REQ-022 A strobe still high in the IDLE cycle after DONE SHALL start a new access (back-to-back allowed).
REQ-023 Latency: request sampled at edge N -> Ready high after edge N+1 (no waits) or N+1+WAIT_CYCLES (waits).
REQ-024 Err SHALL be 0 whenever Ready is 0.

Reset
REQ-025 Reset SHALL force state IDLE, Ready=0, Err=0, Busy=0, Dout=16'h0000, wait counter 0, immediately and independent of Clk.
REQ-026 Memory array contents SHALL NOT be reset.
REQ-027 Reset during WAIT SHALL abort the access; pending write SHALL NOT be committed.

Configuration
REQ-028 Macro MU0_MEM_WAIT_EN defined: WAIT state and counter present, WAIT_CYCLES wait states per access.
REQ-029 Macro MU0_MEM_WAIT_EN undefined: WAIT state and counter removed, IDLE goes straight to DONE, fixed one-cycle latency; WAIT_CYCLES ignored.

Verification
REQ-030 No waits: Wr Addr=12'h010 Din=16'h1234, then Rd 12'h010 -> each Ready one edge after request, Dout=16'h1234, Err=0.
REQ-031 Waits, WAIT_CYCLES=2: Rd at edge N -> Busy high edges N..N+2, Ready high after edge N+3 only.
REQ-032 Rd and Wr both high Addr=12'h005 -> Ready with Err=1, mem[5] and Dout unchanged.
REQ-033 Wr Addr=12'h100 Din=16'hBEEF -> Ready with Err=1; subsequent Rd 12'h000 returns its prior value.
REQ-034 Reset pulsed mid-WAIT of Wr 12'h020 Din=16'hAAAA -> outputs 0 immediately; later Rd 12'h020 returns the old value, not 16'hAAAA.
